// File: rtl/bisr_pkg.sv
// Shared types and sizing helpers for the BISR weight allocator.
// No ports: it supplies the allocator FSM state type, the default geometry
// and index-width helpers used by the allocator and its row matcher.
package bisr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam int unsigned DEF_LOG_ROWS     = 8;
  localparam int unsigned DEF_SPARE_ROWS   = 2;
  localparam int unsigned DEF_COLS         = 8;
  localparam int unsigned DEF_WEIGHT_WIDTH = 8;

  // Index width that never collapses to zero bits for tiny tables.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned phys_rows(input int unsigned log_rows,
                                            input int unsigned spare_rows);
    return log_rows + spare_rows;
  endfunction

endpackage

// File: rtl/bisr_weight_allocator_spare_if.sv
// Weight-row stream between the fault-tolerant weight source and the allocator.
//   w_valid : source has a logical weight row on w_data
//   w_ready : allocator takes the row this cycle
//   w_data  : COLS weights, column c at [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
// master = weight source, slave = allocator.
interface bisr_weight_allocator_spare_if #(
  parameter int unsigned COLS         = 8,
  parameter int unsigned WEIGHT_WIDTH = 8
);
  logic                         w_valid;
  logic                         w_ready;
  logic [COLS*WEIGHT_WIDTH-1:0] w_data;

  modport master (output w_valid, output w_data, input  w_ready);
  modport slave  (input  w_valid, input  w_data, output w_ready);
endinterface

// File: rtl/bisr_row_matcher.sv
// Combinational physical-row selector.
//   fault_map_i  : PHYS_ROWS*COLS fault bits, bit r*COLS+c = PE(r,c) faulty
//   used_i       : physical rows already holding a logical row
//   zero_flags_i : per-column "weight is zero" flags of the candidate row
//   found_o      : some physical row can take the candidate
//   sel_phys_o   : chosen physical row (lowest compatible faulty row first,
//                  otherwise lowest compatible healthy row)
module bisr_row_matcher
  import bisr_pkg::*;
#(
  parameter int unsigned PHYS_ROWS = 10,
  parameter int unsigned COLS      = 8,
  parameter int unsigned PA_W      = 4
) (
  input  logic [PHYS_ROWS*COLS-1:0] fault_map_i,
  input  logic [PHYS_ROWS-1:0]      used_i,
  input  logic [COLS-1:0]           zero_flags_i,
  output logic                      found_o,
  output logic [PA_W-1:0]           sel_phys_o
);

  logic [PHYS_ROWS-1:0] compat;
  logic [PHYS_ROWS-1:0] faulty;
  logic                 found_f, found_h;
  logic [PA_W-1:0]      sel_f, sel_h;

  always_comb begin
    compat = '0;
    faulty = '0;
    for (int unsigned p = 0; p < PHYS_ROWS; p++) begin
      faulty[p] = |fault_map_i[p*COLS +: COLS];
      // Every faulty PE must land on a zero weight.
      compat[p] = !used_i[p] &&
                  ((fault_map_i[p*COLS +: COLS] & ~zero_flags_i) == '0);
    end
  end

  // Faulty rows are consumed first so healthy rows stay free for dense rows.
  always_comb begin
    found_f = 1'b0;
    found_h = 1'b0;
    sel_f   = '0;
    sel_h   = '0;
    for (int unsigned p = 0; p < PHYS_ROWS; p++) begin
      if (!found_f && compat[p] && faulty[p]) begin
        found_f = 1'b1;
        sel_f   = PA_W'(p);
      end
      if (!found_h && compat[p] && !faulty[p]) begin
        found_h = 1'b1;
        sel_h   = PA_W'(p);
      end
    end
    found_o    = found_f || found_h;
    sel_phys_o = found_f ? sel_f : sel_h;
  end

endmodule

// File: rtl/bisr_weight_allocator_spare.sv
// BISR weight allocator with spare rows for a LOG_ROWS x COLS systolic array.
// Places each incoming logical weight row on a physical row whose faulty PEs
// all see zero weights, then serves weights / PE disables / reverse map.
//   clk, rst           : clock, synchronous active-high reset
//   fault_wr_en        : load fault_map_flat (aborts an allocation in progress)
//   fault_map_flat     : bit r*COLS+c = PE(r,c) faulty
//   alloc_start        : clear mapping and begin allocation
//   w_if (slave)       : weight-row stream (w_valid / w_ready / w_data)
//   rd_addr            : physical row to read (1-cycle registered read)
//   rd_weights         : stored weights of that row (0 if unused)
//   rd_log_addr        : logical row mapped there (0 if unused)
//   rd_row_used        : physical row holds a logical row
//   pe_disable_out     : fault bits of that physical row
//   alloc_busy/done/success, fail_row : allocation status
module bisr_weight_allocator_spare
  import bisr_pkg::*;
#(
  parameter int unsigned LOG_ROWS     = DEF_LOG_ROWS,
  parameter int unsigned SPARE_ROWS   = DEF_SPARE_ROWS,
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  localparam int unsigned PHYS_ROWS   = phys_rows(LOG_ROWS, SPARE_ROWS),
  localparam int unsigned PA_W        = idx_w(PHYS_ROWS),
  localparam int unsigned LA_W        = idx_w(LOG_ROWS),
  localparam int unsigned DW          = COLS*WEIGHT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fault_wr_en,
  input  logic [PHYS_ROWS*COLS-1:0] fault_map_flat,
  input  logic                      alloc_start,
  bisr_weight_allocator_spare_if.slave w_if,
  input  logic [PA_W-1:0]           rd_addr,
  output logic [DW-1:0]             rd_weights,
  output logic [LA_W-1:0]           rd_log_addr,
  output logic                      rd_row_used,
  output logic [COLS-1:0]           pe_disable_out,
  output logic                      alloc_busy,
  output logic                      alloc_done,
  output logic                      alloc_success,
  output logic [LA_W-1:0]           fail_row
);

  state_e                    state_q;
  logic [LA_W:0]             cnt_q;
  logic [LA_W-1:0]           fail_row_q;
  logic                      busy_q, done_q, success_q;
  logic [PHYS_ROWS*COLS-1:0] fault_q;
  logic [PHYS_ROWS-1:0]      used_q;
  logic [LA_W-1:0]           map_q [PHYS_ROWS];
  logic [DW-1:0]             wt_q  [PHYS_ROWS];

  logic [COLS-1:0]           zero_flags;
  logic                      found;
  logic [PA_W-1:0]           sel_phys;
  logic                      accept, store, clr_tables;

  always_comb begin
    zero_flags = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      zero_flags[c] = (w_if.w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0);
    end
  end

  bisr_row_matcher #(
    .PHYS_ROWS (PHYS_ROWS),
    .COLS      (COLS),
    .PA_W      (PA_W)
  ) u_matcher (
    .fault_map_i  (fault_q),
    .used_i       (used_q),
    .zero_flags_i (zero_flags),
    .found_o      (found),
    .sel_phys_o   (sel_phys)
  );

  // fault_wr_en outranks alloc_start, which outranks an accept.
  always_comb begin
    accept     = !fault_wr_en && !alloc_start && busy_q && w_if.w_valid;
    store      = accept && found;
    clr_tables = (fault_wr_en && state_q != ST_IDLE) ||
                 (!fault_wr_en && alloc_start);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fail_row_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
    end else if (fault_wr_en) begin
      if (state_q != ST_IDLE) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        fail_row_q <= '0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
        success_q  <= 1'b0;
      end
    end else if (alloc_start) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      fail_row_q <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
    end else if (accept) begin
      if (found) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == (LA_W+1)'(LOG_ROWS-1)) begin
          state_q   <= ST_DONE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          success_q <= 1'b1;
        end
      end else begin
        state_q    <= ST_FAIL;
        fail_row_q <= cnt_q[LA_W-1:0];
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        success_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= '0;
      used_q  <= '0;
      for (int unsigned p = 0; p < PHYS_ROWS; p++) begin
        map_q[p] <= '0;
        wt_q[p]  <= '0;
      end
    end else begin
      if (fault_wr_en) begin
        fault_q <= fault_map_flat;
      end
      if (clr_tables) begin
        used_q <= '0;
        for (int unsigned p = 0; p < PHYS_ROWS; p++) begin
          map_q[p] <= '0;
          wt_q[p]  <= '0;
        end
      end else if (store) begin
        used_q[sel_phys] <= 1'b1;
        map_q[sel_phys]  <= cnt_q[LA_W-1:0];
        wt_q[sel_phys]   <= w_if.w_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !(32'(rd_addr) < PHYS_ROWS)) begin
      rd_weights     <= '0;
      rd_log_addr    <= '0;
      rd_row_used    <= 1'b0;
      pe_disable_out <= '0;
    end else begin
      rd_row_used    <= used_q[rd_addr];
      rd_weights     <= used_q[rd_addr] ? wt_q[rd_addr]  : '0;
      rd_log_addr    <= used_q[rd_addr] ? map_q[rd_addr] : '0;
      pe_disable_out <= fault_q[32'(rd_addr)*COLS +: COLS];
    end
  end

  assign w_if.w_ready  = busy_q;
  assign alloc_busy    = busy_q;
  assign alloc_done    = done_q;
  assign alloc_success = success_q;
  assign fail_row      = fail_row_q;

endmodule
